// File: rtl/prog_loader_pkg.sv
// prog_loader shared types and defaults.
// FSM state encoding, CPU reset length and default bus widths.
package prog_loader_pkg;

  localparam int ADDR_W_DEF    = 13;
  localparam int DATA_W_DEF    = 8;
  localparam int CPURST_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CPURST,
    START_HI,
    START_LO,
    RUN,
    HALT
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte-stream handshake into the program loader.
// master = host side, slave = loader side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              byteValid;
  logic              byteReady;
  logic              byteLast;
  logic [DATA_W-1:0] byteData;

  modport master (
    output byteValid,
    output byteData,
    output byteLast,
    input  byteReady
  );

  modport slave (
    input  byteValid,
    input  byteData,
    input  byteLast,
    output byteReady
  );

endinterface

// File: rtl/prog_loader_run_timer.sv
// loader_run_timer: 16-bit run budget counter.
// expire flags the final budgeted cycle; a zero budget never expires.
module loader_run_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [15:0] budget,
  output logic        expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = en && (budget != 16'd0)
               && (cnt == budget - 16'd1);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams an image into program memory, then starts and times a CPU run.
// Define PROG_LOADER_CHECKSUM_EN to keep a modulo-2^DATA_W sum of written bytes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int START_TMO = 4
) (
  input  logic              clk,
  input  logic              rst,
  prog_loader_if.slave      host,
  input  logic [15:0]       runCycles,
  input  logic              abort,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEn,
  output logic              cpuStart,
  output logic              cpuRstOut,
  input  logic              cpuDone,
  output logic              busy,
  output logic              finished,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  state_t            state;
  state_t            state_n;
  // top bit marks a completely filled memory
  logic [ADDR_W:0]   addr;
  logic [7:0]        wcnt;
  logic [15:0]       budget;
  logic              hs;
  logic              full;
  logic              wr;
  logic              set_err;
  logic              clr_err;
  logic              latch;
  logic              expire;

  assign hs   = host.byteValid && host.byteReady;
  assign full = addr[ADDR_W];

  loader_run_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != RUN),
    .en     (state == RUN),
    .budget (budget),
    .expire (expire)
  );

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    set_err = 1'b0;
    clr_err = 1'b0;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) begin
          clr_err = 1'b1;
          wr      = 1'b1;
          latch   = host.byteLast;
          state_n = host.byteLast ? CPURST : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          state_n = HALT;
        end else if (hs && full) begin
          set_err = 1'b1;
          state_n = HALT;
        end else if (hs) begin
          wr      = 1'b1;
          latch   = host.byteLast;
          state_n = host.byteLast ? CPURST : LOAD;
        end
      end
      CPURST: begin
        if (abort) begin
          state_n = HALT;
        end else if (wcnt == 8'(CPURST_CYCLES - 1)) begin
          state_n = START_HI;
        end
      end
      START_HI: begin
        if (abort) begin
          state_n = HALT;
        end else if (!cpuDone) begin
          state_n = START_LO;
        end else if (wcnt == 8'(START_TMO - 1)) begin
          set_err = 1'b1;
          state_n = HALT;
        end
      end
      START_LO: state_n = abort ? HALT : RUN;
      RUN: begin
        if (abort || expire) begin
          state_n = HALT;
        end
      end
      HALT:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      addr           <= '0;
      wcnt           <= '0;
      budget         <= '0;
      error          <= 1'b0;
      host.byteReady <= 1'b0;
      busy           <= 1'b0;
      cpuStart       <= 1'b0;
      cpuRstOut      <= 1'b1;
      finished       <= 1'b0;
      memWriteEn     <= 1'b0;
      memAddress     <= '0;
      memWriteData   <= '0;
    end else begin
      state <= state_n;
      wcnt  <= (state_n != state) ? 8'd0 : wcnt + 8'd1;
      if (state == HALT) begin
        addr <= '0;
      end else if (wr) begin
        addr <= addr + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (latch) begin
        budget <= runCycles;
      end
      if (clr_err) begin
        error <= 1'b0;
      end else if (set_err) begin
        error <= 1'b1;
      end
      memWriteEn <= wr;
      if (wr) begin
        memAddress   <= addr[ADDR_W-1:0];
        memWriteData <= host.byteData;
      end
      // outputs registered from the next state so they line up with it
      host.byteReady <= (state_n == IDLE) || (state_n == LOAD);
      busy           <= state_n != IDLE;
      cpuStart       <= state_n == START_HI;
      cpuRstOut      <= (state_n == CPURST) || (state_n == HALT);
      finished       <= state_n == HALT;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (wr) begin
      sum <= (state == IDLE) ? host.byteData : sum + host.byteData;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and random loads checked against an image-level model.
// Small ADDR_W so memory-full behaviour is reachable quickly.
module tb_prog_loader;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   runCycles = '0;
  logic          abort = 1'b0;
  logic          cpuDone = 1'b1;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData;
  logic          memWriteEn;
  logic          cpuStart;
  logic          cpuRstOut;
  logic          busy;
  logic          finished;
  logic          error;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [7:0] img[$];
  int         wa[$];
  int         wd[$];

  prog_loader_if #(.DATA_W(DW)) host ();

  prog_loader #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .START_TMO (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (host),
    .runCycles    (runCycles),
    .abort        (abort),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWriteEn   (memWriteEn),
    .cpuStart     (cpuStart),
    .cpuRstOut    (cpuRstOut),
    .cpuDone      (cpuDone),
    .busy         (busy),
    .finished     (finished),
    .error        (error),
    .checksum     (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && memWriteEn) begin
      wa.push_back(int'(memAddress));
      wd.push_back(int'(memWriteData));
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer img[], then follow the CPU handshake until the finished pulse.
  task automatic run_job(input int rc, input int dly, input bit ab,
                         input bit ovf, input int amid);
    int n = img.size();
    int cap = 1 << AW;
    bit eab = ab && (n > 1) && !ovf;
    bit tmo = dly > TMO;
    int nw, erst, estart, emid, sum;
    bit eerr;
    int rcnt = 0;
    int scnt = 0;
    int mcnt = 0;
    bit done = 0;
    if (ovf) nw = cap;
    else if (eab) nw = n - 1;
    else nw = n;
    if (ovf || eab) begin
      erst = 0; estart = 0; emid = 0; eerr = ovf;
    end else begin
      erst   = 2;
      estart = tmo ? TMO : dly;
      emid   = tmo ? 0 : ((rc == 0) ? amid : rc + 1);
      eerr   = tmo;
    end
    sum = 0;
    for (int i = 0; i < nw; i++) sum += int'(img[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    sum = sum % 256;
`else
    sum = 0;
`endif
    runCycles = 16'(rc);
    cpuDone = 1'b1;
    abort = 1'b0;
    wa.delete();
    wd.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        host.byteValid = 1'b0;
        tick();
      end
      check("ready", host.byteReady, 1);
      host.byteValid = 1'b1;
      host.byteData  = img[i];
      host.byteLast  = !ovf && (i == n - 1);
      abort          = ab && (i == n - 1);
      tick();
      if (i == 0) check("err_clr", error, 0);
    end
    host.byteValid = 1'b0;
    host.byteLast  = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (cpuRstOut && !finished) rcnt++;
      if (cpuStart) begin
        scnt++;
        if (scnt == dly) cpuDone = 1'b0;
      end
      if (busy && !cpuStart && !cpuRstOut) begin
        mcnt++;
        if (amid != 0 && mcnt == amid) abort = 1'b1;
      end
      if (finished) begin
        done = 1;
        check("halt_rst", cpuRstOut, 1);
        check("halt_err", error, 32'(eerr));
        check("csum", checksum, 32'(sum));
      end else begin
        tick();
      end
    end
    if (!done) check("finish_timeout", 0, 1);
    abort = 1'b0;
    check("rst_cycles", rcnt, erst);
    check("start_cycles", scnt, estart);
    check("run_cycles", mcnt, emid);
    check("nwrites", wa.size(), nw);
    for (int i = 0; i < nw && i < wa.size(); i++) begin
      check("waddr", wa[i], i);
      check("wdata", wd[i], int'(img[i]));
    end
    tick();
    check("fin_pulse", finished, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", host.byteReady, 1);
    check("err_hold", error, 32'(eerr));
    check("csum_hold", checksum, 32'(sum));
  endtask

  initial begin
    host.byteValid = 1'b0;
    host.byteLast  = 1'b0;
    host.byteData  = '0;
    #12;
    check("rst_ready", host.byteReady, 0);
    check("rst_cpurst", cpuRstOut, 1);
    check("rst_busy", busy, 0);
    check("rst_wen", memWriteEn, 0);
    check("rst_err", error, 0);
    check("rst_csum", checksum, 0);
    check("rst_start", cpuStart, 0);
    check("rst_fin", finished, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_ready", host.byteReady, 1);
    check("post_cpurst", cpuRstOut, 0);

    img = '{8'h11, 8'h22, 8'h33};
    run_job(5, 2, 0, 0, 0);
    img = '{8'hF0, 8'h20};
    run_job(1, 1, 0, 0, 0);
    img = '{8'h01, 8'h02};
    run_job(3, 9, 0, 0, 0);
    img = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    run_job(2, 1, 0, 1, 0);
    img = '{8'hAA, 8'hBB, 8'hCC};
    run_job(4, 1, 1, 0, 0);
    img = '{8'h5A};
    run_job(2, 3, 1, 0, 0);
    img = '{8'h07, 8'h08};
    run_job(0, 1, 0, 0, 7);

    host.byteValid = 1'b1;
    host.byteLast  = 1'b0;
    host.byteData  = 8'h99;
    tick();
    tick();
    host.byteValid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_wen", memWriteEn, 0);
    check("arst_busy", busy, 0);
    check("arst_cpurst", cpuRstOut, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    img = '{8'h3C, 8'h4D};
    run_job(2, 1, 0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      int n = $urandom_range(1, 4);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      run_job($urandom_range(1, 12), $urandom_range(1, 6),
              $urandom_range(0, 5) == 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
